// File: rtl/adder_pkg.sv
// Shared constants for the pipelined CLA adder/subtractor.
// Optional status flags are enabled with `define ADDER_FLAGS_EN.
package adder_pkg;

    localparam int WIDTH_DEFAULT = 64;
    localparam int CHUNK_DEFAULT = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int nstg(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/cla_chunk_adder.sv
// Combinational CHUNK-bit carry-look-ahead slice.
// Every carry is a flat sum-of-products of generate/propagate terms.
module cla_chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;

    function automatic logic la_carry(
        input logic [CHUNK-1:0] gi,
        input logic [CHUNK-1:0] pi,
        input logic             ci,
        input int               idx
    );
        logic cc;
        logic pp;
        cc = gi[idx];
        pp = pi[idx];
        for (int j = idx - 1; j >= 0; j--) begin
            cc = cc | (pp & gi[j]);
            pp = pp & pi[j];
        end
        return cc | (pp & ci);
    endfunction

    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = la_carry(g, p, cin, i);
        end
        sum  = p ^ c[CHUNK-1:0];
        cout = c[CHUNK];
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one CHUNK-bit slice per stage.
// `define ADDER_FLAGS_EN adds registered out_zero/out_neg/out_ovf.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef ADDER_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`endif
);

    localparam int NSTG = nstg(WIDTH, CHUNK);

    logic             adv;
    logic             sub;
    logic [WIDTH-1:0] bx;

    always_comb begin
        adv = !out_valid || out_ready;
        sub = (in_sub == OP_SUB);
        bx  = sub ? ~in_b : in_b;
    end

    assign in_ready = adv;

    // Each stage keeps only the sum bits already resolved and the
    // operand bits not yet consumed, so register widths shrink/grow.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int DONE = (k + 1) * CHUNK;
        localparam int REM  = WIDTH - DONE;

        logic [CHUNK-1:0] a_c;
        logic [CHUNK-1:0] b_c;
        logic [CHUNK-1:0] s_c;
        logic             ci;
        logic             co;
        logic             v_d;
        logic             v_q;
        logic             c_d;
        logic             c_q;
        logic [DONE-1:0]  sum_d;
        logic [DONE-1:0]  sum_q;

        if (k == 0) begin : g_head
            always_comb begin
                a_c   = in_a[CHUNK-1:0];
                b_c   = bx[CHUNK-1:0];
                ci    = sub ? 1'b1 : in_cin;
                v_d   = in_valid;
                sum_d = s_c;
            end
        end else begin : g_body
            always_comb begin
                a_c   = g_stg[k-1].g_rem.ra_q[CHUNK-1:0];
                b_c   = g_stg[k-1].g_rem.rb_q[CHUNK-1:0];
                ci    = g_stg[k-1].c_q;
                v_d   = g_stg[k-1].v_q;
                sum_d = {s_c, g_stg[k-1].sum_q};
            end
        end

        cla_chunk_adder #(
            .CHUNK(CHUNK)
        ) u_cla (
            .a   (a_c),
            .b   (b_c),
            .cin (ci),
            .sum (s_c),
            .cout(co)
        );

        assign c_d = co;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_d;
                c_q   <= c_d;
                sum_q <= sum_d;
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] ra_d;
            logic [REM-1:0] ra_q;
            logic [REM-1:0] rb_d;
            logic [REM-1:0] rb_q;

            if (k == 0) begin : g_src0
                always_comb begin
                    ra_d = in_a[WIDTH-1:CHUNK];
                    rb_d = bx[WIDTH-1:CHUNK];
                end
            end else begin : g_srcn
                always_comb begin
                    ra_d = g_stg[k-1].g_rem.ra_q[REM+CHUNK-1:CHUNK];
                    rb_d = g_stg[k-1].g_rem.rb_q[REM+CHUNK-1:CHUNK];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (adv) begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].v_q;
    assign out_sum   = g_stg[NSTG-1].sum_q;
    assign out_cout  = g_stg[NSTG-1].c_q;

`ifdef ADDER_FLAGS_EN
    logic zero_d;
    logic zero_q;
    logic neg_d;
    logic neg_q;
    logic ovf_d;
    logic ovf_q;

    // Top slice holds the operand sign bits, so overflow is judged there.
    always_comb begin
        zero_d = (g_stg[NSTG-1].sum_d == '0);
        neg_d  = g_stg[NSTG-1].sum_d[WIDTH-1];
        ovf_d  = (g_stg[NSTG-1].a_c[CHUNK-1] == g_stg[NSTG-1].b_c[CHUNK-1])
              && (g_stg[NSTG-1].s_c[CHUNK-1] != g_stg[NSTG-1].a_c[CHUNK-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_zero = zero_q;
    assign out_neg  = neg_q;
    assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (64/16 and 32/8 builds).
// Flag checks are compiled in with `define ADDER_FLAGS_EN.
module tb_pipelined_cla_adder;
    import adder_pkg::*;

    localparam int W    = 64;
    localparam int NSTG = 4;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    logic         i32_valid;
    logic         i32_ready;
    logic [31:0]  i32_a;
    logic [31:0]  i32_b;
    logic         i32_cin;
    logic         o32_valid;
    logic [31:0]  o32_sum;
    logic         o32_cout;

`ifdef ADDER_FLAGS_EN
    logic out_zero;
    logic out_neg;
    logic out_ovf;
    logic o32_zero;
    logic o32_neg;
    logic o32_ovf;
`endif

    pipelined_cla_adder #(.WIDTH(64), .CHUNK(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
`ifdef ADDER_FLAGS_EN
        ,
        .out_zero (out_zero),
        .out_neg  (out_neg),
        .out_ovf  (out_ovf)
`endif
    );

    pipelined_cla_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (i32_valid),
        .in_ready (i32_ready),
        .in_a     (i32_a),
        .in_b     (i32_b),
        .in_cin   (i32_cin),
        .in_sub   (OP_ADD),
        .out_valid(o32_valid),
        .out_ready(1'b1),
        .out_sum  (o32_sum),
        .out_cout (o32_cout)
`ifdef ADDER_FLAGS_EN
        ,
        .out_zero (o32_zero),
        .out_neg  (o32_neg),
        .out_ovf  (o32_ovf)
`endif
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         zero;
        logic         neg;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic         hold_pending = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout;

    function automatic exp_t model(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         cin,
        input logic         sub
    );
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   r;
        bx = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.zero = (r[W-1:0] == '0);
        e.neg  = r[W-1];
        e.ovf  = (a[W-1] == bx[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        logic acc;
        int   n;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("wait_out", out_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    // Output monitor and scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            hold_pending = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, (!out_valid || out_ready));
            if (hold_pending) begin
                chk("stall_hold", {out_valid, out_cout, out_sum},
                    {1'b1, hold_cout, hold_sum});
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_result", {out_cout, out_sum}, {e.cout, e.sum});
`ifdef ADDER_FLAGS_EN
                    chk("sb_flags", {out_zero, out_neg, out_ovf},
                        {e.zero, e.neg, e.ovf});
`endif
                end
            end
            hold_pending = out_valid && !out_ready;
            hold_sum     = out_sum;
            hold_cout    = out_cout;
            if (in_valid && in_ready) begin
                sb.push_back(model(in_a, in_b, in_cin, in_sub));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = OP_ADD;
        out_ready = 1'b1;
        i32_valid = 1'b0;
        i32_a     = '0;
        i32_b     = '0;
        i32_cin   = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_o32_valid", o32_valid, 0);
`ifdef ADDER_FLAGS_EN
        chk("rst_flags", {out_zero, out_neg, out_ovf}, 0);
`endif
        align();
        rst_n = 1'b1;

        // full carry ripple, latency
        in_a     = '1;
        in_b     = 64'd1;
        in_cin   = 1'b0;
        in_sub   = OP_ADD;
        in_valid = 1'b1;
        @(negedge clk);
        align();
        in_valid = 1'b0;
        for (int i = 1; i <= NSTG; i++) begin
            @(negedge clk);
            chk("lat_add_valid", out_valid, (i == NSTG));
        end
        chk("ripple_sum", out_sum, 0);
        chk("ripple_cout", out_cout, 1);

        // subtract
        align();
        send(64'd5, 64'd7, 1'b1, OP_SUB);
        wait_out();
        chk("sub_5_7_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_5_7_cout", out_cout, 0);
        align();
        send(64'd7, 64'd5, 1'b0, OP_SUB);
        wait_out();
        chk("sub_7_5_sum", out_sum, 64'd2);
        chk("sub_7_5_cout", out_cout, 1);
        drain();

        // backpressure: out_ready low in cycles 6..9
        align();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send({$urandom, $urandom}, {$urandom, $urandom},
                         1'(i % 2), 1'(i % 3 == 0));
                end
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    out_ready = !(c >= 6 && c <= 9);
                    @(negedge clk);
                    if (c >= 6 && c <= 9) begin
                        chk("bp_in_ready", in_ready, 0);
                    end
                    align();
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // reset with operations in flight
        align();
        for (int i = 0; i < 5; i++) begin
            send(64'(i + 100), 64'(i * 3), 1'b0, OP_ADD);
        end
        chk("mid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", out_sum, 0);
        align();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_no_out", out_valid, 0);
            @(negedge clk);
        end
        chk("post_rst_sb", sb.size(), 0);

        // 32-bit / 8-bit slice build
        align();
        i32_a     = 32'h00FF_00FF;
        i32_b     = 32'h0001_0001;
        i32_cin   = 1'b1;
        i32_valid = 1'b1;
        @(negedge clk);
        chk("w32_ready", i32_ready, 1);
        align();
        i32_valid = 1'b0;
        for (int i = 1; i <= NSTG; i++) begin
            @(negedge clk);
            chk("w32_lat_valid", o32_valid, (i == NSTG));
        end
        chk("w32_sum", o32_sum, 32'h0100_0101);
        chk("w32_cout", o32_cout, 0);

`ifdef ADDER_FLAGS_EN
        align();
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD);
        wait_out();
        chk("flag_ovf", out_ovf, 1);
        chk("flag_neg", out_neg, 1);
        chk("flag_zero_n", out_zero, 0);
        align();
        send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, OP_SUB);
        wait_out();
        chk("flag_zero", out_zero, 1);
`endif

        // random traffic with bubbles and stalls
        align();
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom % 2);
            in_a      = {$urandom, $urandom};
            in_b      = {$urandom, $urandom};
            in_cin    = 1'($urandom % 2);
            in_sub    = 1'($urandom % 2);
            out_ready = (($urandom % 4) != 0);
            align();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
